// File: rtl/stream_monitor.sv
// stream_monitor: passive multi-channel Avalon-ST tap. Keeps per-channel
// traffic counters (flits, packets, SOPs, bytes, stalls) plus SOP/EOP
// framing-error counters, with an atomic snapshot/clear into a shadow bank
// that software reads back through a one-cycle registered read port.
module stream_monitor #(
  parameter int NUM_CH  = 4,
  parameter int EMPTY_W = 6,
  parameter int CNT_W   = 32,
  parameter int SAT     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          mon_valid,
  input  logic [NUM_CH-1:0]          mon_ready,
  input  logic [NUM_CH-1:0]          mon_sop,
  input  logic [NUM_CH-1:0]          mon_eop,
  input  logic [NUM_CH*EMPTY_W-1:0]  mon_empty,
  input  logic                       snap_req,
  input  logic                       clr_req,
  input  logic                       rd_en,
  input  logic [$clog2(NUM_CH)+2:0]  rd_addr,
  output logic [CNT_W-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       err_irq
);

  // Live counters per channel; the status word (index 7) is built on the fly.
  localparam int NCNT  = 7;
  localparam int BPB_W = EMPTY_W + 1;
  localparam logic [BPB_W-1:0] BPB = {1'b1, {EMPTY_W{1'b0}}};
  localparam logic SAT_EN = (SAT != 0);

  localparam int IDX_FLIT   = 0;
  localparam int IDX_PKT    = 1;
  localparam int IDX_SOP    = 2;
  localparam int IDX_BYTE   = 3;
  localparam int IDX_STALL  = 4;
  localparam int IDX_ESOP   = 5;
  localparam int IDX_ENOSOP = 6;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  state_t            state_r     [NUM_CH];
  state_t            state_nxt_s [NUM_CH];
  logic [NUM_CH-1:0] acc_s;
  logic [NUM_CH-1:0] stall_s;
  logic [BPB_W-1:0]  byt_s       [NUM_CH];
  logic [CNT_W-1:0]  add_s       [NUM_CH][NCNT];
  logic [CNT_W-1:0]  cnt_r       [NUM_CH][NCNT];
  logic [CNT_W-1:0]  cnt_nxt_s   [NUM_CH][NCNT];
  logic [NCNT-1:0]   ovf_s       [NUM_CH];
  logic [NCNT-1:0]   sat_r       [NUM_CH];
  logic [CNT_W-1:0]  shd_r       [NUM_CH][8];
  logic [31:0]       rd_ch_s;
  logic [CNT_W-1:0]  rd_word_s;
  logic              err_any_s;

  // Counter add: returns {overflow, value}. In saturating mode an add that
  // would carry out clamps to all-ones and flags overflow; otherwise it wraps.
  function automatic logic [CNT_W:0] cnt_add(input logic [CNT_W-1:0] val,
                                             input logic [CNT_W-1:0] addend,
                                             input logic             sat_en);
    logic [CNT_W:0] sum;
    sum = {1'b0, val} + {1'b0, addend};
    if (sat_en && sum[CNT_W]) begin
      cnt_add = {1'b1, {CNT_W{1'b1}}};
    end else begin
      cnt_add = {1'b0, sum[CNT_W-1:0]};
    end
  endfunction

  // Status word: {zeros, in_pkt, sticky saturation flags}.
  function automatic logic [CNT_W-1:0] status_word(input state_t st,
                                                   input logic [NCNT-1:0] sat);
    status_word = CNT_W'({(st == ST_IN_PKT), sat});
  endfunction

  // Decode each channel's handshake into per-counter addends.
  always_comb begin
    acc_s   = '0;
    stall_s = '0;
    byt_s   = '{default: '0};
    add_s   = '{default: '0};
    for (int c = 0; c < NUM_CH; c++) begin
      acc_s[c]   = mon_valid[c] & mon_ready[c];
      stall_s[c] = mon_valid[c] & ~mon_ready[c];
      if (mon_eop[c]) begin
        byt_s[c] = BPB - {1'b0, mon_empty[c*EMPTY_W +: EMPTY_W]};
      end else begin
        byt_s[c] = BPB;
      end
      add_s[c][IDX_FLIT]   = CNT_W'(acc_s[c]);
      add_s[c][IDX_PKT]    = CNT_W'(acc_s[c] & mon_eop[c]);
      add_s[c][IDX_SOP]    = CNT_W'(acc_s[c] & mon_sop[c]);
      add_s[c][IDX_BYTE]   = acc_s[c] ? CNT_W'(byt_s[c]) : {CNT_W{1'b0}};
      add_s[c][IDX_STALL]  = CNT_W'(stall_s[c]);
      add_s[c][IDX_ESOP]   = CNT_W'(acc_s[c] & mon_sop[c] & (state_r[c] == ST_IN_PKT));
      add_s[c][IDX_ENOSOP] = CNT_W'(acc_s[c] & ~mon_sop[c] & (state_r[c] == ST_IDLE));
    end
  end

  // Framing FSM next state: a SOP always (re)starts a packet, EOP closes it.
  always_comb begin
    state_nxt_s = state_r;
    for (int c = 0; c < NUM_CH; c++) begin
      if (acc_s[c]) begin
        case (state_r[c])
          ST_IDLE: begin
            if (mon_sop[c] && !mon_eop[c]) begin
              state_nxt_s[c] = ST_IN_PKT;
            end else begin
              state_nxt_s[c] = ST_IDLE;
            end
          end
          ST_IN_PKT: begin
            if (mon_eop[c]) begin
              state_nxt_s[c] = ST_IDLE;
            end else begin
              state_nxt_s[c] = ST_IN_PKT;
            end
          end
          default: state_nxt_s[c] = ST_IDLE;
        endcase
      end else begin
        state_nxt_s[c] = state_r[c];
      end
    end
  end

  // Framing FSM state register; clear requests deliberately leave it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_r[c] <= ST_IDLE;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_r[c] <= state_nxt_s[c];
      end
    end
  end

  // Per-channel, per-counter adders; each channel's arithmetic is independent.
  always_comb begin
    cnt_nxt_s = '{default: '0};
    ovf_s     = '{default: '0};
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < NCNT; i++) begin
        {ovf_s[c][i], cnt_nxt_s[c][i]} = cnt_add(cnt_r[c][i], add_s[c][i], SAT_EN);
      end
    end
  end

  // Live counters and sticky saturation flags; clear drops this cycle's events.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_req) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sat_r[c] <= '0;
        for (int i = 0; i < NCNT; i++) begin
          cnt_r[c][i] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        sat_r[c] <= sat_r[c] | ovf_s[c];
        for (int i = 0; i < NCNT; i++) begin
          cnt_r[c][i] <= cnt_nxt_s[c][i];
        end
      end
    end
  end

  // Shadow bank: captures pre-event live values, so snap+clear is atomic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < 8; i++) begin
          shd_r[c][i] <= '0;
        end
      end
    end else if (snap_req) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < NCNT; i++) begin
          shd_r[c][i] <= cnt_r[c][i];
        end
        shd_r[c][7] <= status_word(state_r[c], sat_r[c]);
      end
    end else begin
      shd_r <= shd_r;
    end
  end

  // Read mux over the shadow bank; unmapped channels read as zero.
  always_comb begin
    rd_ch_s   = 32'(rd_addr >> 3);
    rd_word_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_word_s = rd_word_s | ((rd_ch_s == 32'(c)) ? shd_r[c][rd_addr[2:0]] : {CNT_W{1'b0}});
    end
  end

  // Registered read port; data holds its last value between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_word_s;
      end else begin
        rd_data <= rd_data;
      end
    end
  end

  // Any nonzero live framing-error counter across all channels.
  always_comb begin
    err_any_s = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      err_any_s = err_any_s | (|cnt_r[c][IDX_ESOP]) | (|cnt_r[c][IDX_ENOSOP]);
    end
  end

  // Error interrupt, registered one cycle behind the live counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_irq <= 1'b0;
    end else begin
      err_irq <= err_any_s;
    end
  end

endmodule

// File: tb/tb_stream_monitor.sv
// Directed self-checking bench for stream_monitor. Two instances share the
// stimulus: one saturating, one wrapping, both with 16-bit counters and five
// channels (so an out-of-range channel number is addressable).
module tb_stream_monitor;
  localparam int NCH = 5;
  localparam int EW  = 6;
  localparam int CW  = 16;
  localparam int AW  = $clog2(NCH) + 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    mon_valid, mon_ready, mon_sop, mon_eop;
  logic [NCH*EW-1:0] mon_empty;
  logic              snap_req, clr_req, rd_en;
  logic [AW-1:0]     rd_addr;
  logic [CW-1:0]     rd_data, rd_data0;
  logic              rd_valid, rd_valid0, err_irq, err_irq0;

  int checks = 0;
  int errors = 0;

  stream_monitor #(.NUM_CH(NCH), .EMPTY_W(EW), .CNT_W(CW), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .mon_valid(mon_valid), .mon_ready(mon_ready),
    .mon_sop(mon_sop), .mon_eop(mon_eop), .mon_empty(mon_empty),
    .snap_req(snap_req), .clr_req(clr_req), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .err_irq(err_irq));

  stream_monitor #(.NUM_CH(NCH), .EMPTY_W(EW), .CNT_W(CW), .SAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mon_valid(mon_valid), .mon_ready(mon_ready),
    .mon_sop(mon_sop), .mon_eop(mon_eop), .mon_empty(mon_empty),
    .snap_req(snap_req), .clr_req(clr_req), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .err_irq(err_irq0));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mon_valid = '0;
    mon_ready = '0;
    mon_sop   = '0;
    mon_eop   = '0;
    mon_empty = '0;
  endtask

  task automatic set_beat(input int ch, input logic sop, input logic eop, input logic [EW-1:0] emp);
    mon_valid[ch] = 1'b1;
    mon_ready[ch] = 1'b1;
    mon_sop[ch]   = sop;
    mon_eop[ch]   = eop;
    mon_empty[ch*EW +: EW] = emp;
  endtask

  task automatic beat(input int ch, input logic sop, input logic eop, input logic [EW-1:0] emp);
    idle();
    set_beat(ch, sop, eop, emp);
    tick();
    idle();
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic rd(input int ch, input int idx);
    rd_en   = 1'b1;
    rd_addr = {3'(ch), 3'(idx)};
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input int ch, input int idx, input logic [CW-1:0] exp);
    rd(ch, idx);
    check({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; snap_req = 1'b0; clr_req = 1'b0; rd_en = 1'b0; rd_addr = '0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset rd_data",  32'(rd_data),  32'd0);
    check("reset err_irq",  32'(err_irq),  32'd0);
    chk_rd("reset shadow ch0 flits", 0, 0, 16'd0);

    // Saturation: 65540 single-beat packets on ch3
    idle();
    set_beat(3, 1'b1, 1'b1, 6'd0);
    repeat (65540) tick();
    idle();
    pulse_snap();
    rd(3, 0);
    check("sat flits SAT=1", 32'(rd_data),  32'hFFFF);
    check("sat flits SAT=0", 32'(rd_data0), 32'd4);
    rd(3, 7);
    check("sat status SAT=1", 32'(rd_data),  32'h000F);
    check("sat status SAT=0", 32'(rd_data0), 32'h0000);
    pulse_clr();

    // 3-beat packet on ch0
    beat(0, 1'b1, 1'b0, 6'd0);
    beat(0, 1'b0, 1'b0, 6'd0);
    beat(0, 1'b0, 1'b1, 6'd10);
    pulse_snap();
    chk_rd("pkt3 flits",  0, 0, 16'd3);
    chk_rd("pkt3 pkts",   0, 1, 16'd1);
    chk_rd("pkt3 sops",   0, 2, 16'd1);
    chk_rd("pkt3 bytes",  0, 3, 16'd182);
    chk_rd("pkt3 stalls", 0, 4, 16'd0);
    chk_rd("pkt3 esop",   0, 5, 16'd0);
    chk_rd("pkt3 enosop", 0, 6, 16'd0);
    chk_rd("pkt3 status", 0, 7, 16'd0);
    chk_rd("pkt3 ch3 cleared", 3, 0, 16'd0);

    // Stalls on ch1 then a single-beat packet
    idle();
    mon_valid[1] = 1'b1;
    repeat (5) tick();
    beat(1, 1'b1, 1'b1, 6'd0);
    pulse_snap();
    chk_rd("stall stalls", 1, 4, 16'd5);
    chk_rd("stall flits",  1, 0, 16'd1);
    chk_rd("stall bytes",  1, 3, 16'd64);

    // Framing errors on ch2
    beat(2, 1'b1, 1'b0, 6'd0);
    beat(2, 1'b1, 1'b1, 6'd0);
    check("irq low 1 cycle after err", 32'(err_irq), 32'd0);
    beat(2, 1'b0, 1'b1, 6'd0);
    check("irq high 2 cycles after err", 32'(err_irq), 32'd1);
    pulse_snap();
    chk_rd("frm esop",   2, 5, 16'd1);
    chk_rd("frm enosop", 2, 6, 16'd1);
    chk_rd("frm pkts",   2, 1, 16'd2);
    chk_rd("frm status", 2, 7, 16'd0);
    check("irq held before clear", 32'(err_irq), 32'd1);
    pulse_clr();
    tick();
    check("irq low after clear", 32'(err_irq), 32'd0);

    // Atomic read-and-clear with a beat in the same cycle
    beat(0, 1'b1, 1'b1, 6'd0);
    beat(0, 1'b1, 1'b1, 6'd0);
    idle();
    set_beat(0, 1'b1, 1'b1, 6'd0);
    snap_req = 1'b1;
    clr_req  = 1'b1;
    tick();
    snap_req = 1'b0;
    clr_req  = 1'b0;
    idle();
    chk_rd("atomic shadow pre-event", 0, 0, 16'd2);
    pulse_snap();
    chk_rd("atomic live cleared", 0, 0, 16'd0);
    beat(0, 1'b1, 1'b1, 6'd0);
    pulse_snap();
    chk_rd("atomic next beat", 0, 0, 16'd1);

    // Read issued together with snap returns the old shadow
    beat(0, 1'b1, 1'b1, 6'd0);
    snap_req = 1'b1;
    rd_en    = 1'b1;
    rd_addr  = {3'd0, 3'd0};
    tick();
    snap_req = 1'b0;
    rd_en    = 1'b0;
    check("snap+read old value", 32'(rd_data), 32'd1);
    tick();
    check("rd_valid drops when idle", 32'(rd_valid), 32'd0);
    chk_rd("snap+read new value", 0, 0, 16'd2);

    // Reset mid-packet drops packet context
    beat(0, 1'b1, 1'b0, 6'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid reset rd_valid", 32'(rd_valid), 32'd0);
    check("mid reset rd_data",  32'(rd_data),  32'd0);
    check("mid reset err_irq",  32'(err_irq),  32'd0);
    beat(0, 1'b0, 1'b1, 6'd5);
    pulse_snap();
    chk_rd("rst enosop", 0, 6, 16'd1);
    chk_rd("rst esop",   0, 5, 16'd0);
    chk_rd("rst bytes",  0, 3, 16'd59);
    chk_rd("rst flits",  0, 0, 16'd1);
    chk_rd("oor ch5",    5, 0, 16'd0);
    chk_rd("rst pkts",   0, 1, 16'd1);
    chk_rd("oor ch7",    7, 3, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_monitor.md
# stream_monitor

Parametrised, multi-channel, non-intrusive monitor for Avalon-ST packet interfaces in the Pigasus datapath. It taps `NUM_CH` valid/ready streams and keeps per-channel traffic counters: flits, packets, SOPs, bytes and stall cycles. It also runs a per-channel SOP/EOP framing checker that counts protocol violations. Software can atomically snapshot (and optionally clear) all counters, then read them back through a simple registered read port.

## Interface
Parameters:
- `NUM_CH`, default 4: number of monitored channels (1..16).
- `EMPTY_W`, default 6: width of each `empty` field. Bytes per beat `BPB = 2**EMPTY_W` (64).
- `CNT_W`, default 32: width of each counter (16..64).
- `SAT`, default 1: 1 = counters saturate at all-ones; 0 = counters wrap.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `mon_valid`, in, `NUM_CH`: per-channel valid.
- `mon_ready`, in, `NUM_CH`: per-channel ready.
- `mon_sop`, in, `NUM_CH`: per-channel start of packet.
- `mon_eop`, in, `NUM_CH`: per-channel end of packet.
- `mon_empty`, in, `NUM_CH*EMPTY_W`: per-channel empty. Channel c occupies bits `[c*EMPTY_W +: EMPTY_W]`.
- `snap_req`, in, 1: one-cycle pulse; copy all live counters into the shadow bank.
- `clr_req`, in, 1: one-cycle pulse; zero all live counters.
- `rd_en`, in, 1: read strobe.
- `rd_addr`, in, `$clog2(NUM_CH)+3`: address = `{channel, index[2:0]}`.
- `rd_data`, out, `CNT_W`: shadow value at the requested address.
- `rd_valid`, out, 1: `rd_data` is valid.
- `err_irq`, out, 1: high while any channel has a nonzero live error counter.

## Operation
- **Beat accepted:** `valid & ready` on channel c.
- **Stall:** `valid & !ready`.
- **Counter index map, per channel:**
  - 0: flits (accepted beats).
  - 1: packets (accepted beats with `eop`).
  - 2: SOPs.
  - 3: bytes. Each accepted beat adds `BPB` if `!eop`, or `BPB - empty` if `eop`. The addend is zero-extended to `CNT_W`.
  - 4: stall cycles.
  - 5: `err_sop`, an SOP accepted while the channel is in IN_PKT.
  - 6: `err_nosop`, a beat without `sop` accepted while the channel is in IDLE.
  - 7: status, returned as `{zeros, in_pkt, sat[6:0]}`. `sat[i]` is sticky and means counter i has saturated; it is only ever set when `SAT=1`.
- **Framing FSM (per channel, states IDLE / IN_PKT), evaluated on accepted beats only:**
  - IDLE, `sop & !eop` → IN_PKT.
  - IDLE, `sop & eop` → IDLE (single-beat packet).
  - IDLE, `!sop` → increment `err_nosop`, stay in IDLE. The beat is still counted in flits, bytes and, if it carries `eop`, packets.
  - IN_PKT, `sop` → increment `err_sop`. The beat is treated as a new packet start, so the next state is IDLE if `eop`, otherwise IN_PKT.
  - IN_PKT, `!sop & eop` → IDLE.
  - IN_PKT, neither flag → stay in IN_PKT.
- **Saturation (`SAT=1`):** a counter at all-ones holds its value and sets its `sat` bit. With `SAT=0`, counters wrap modulo `2**CNT_W`.
- **Snapshot:** `snap_req` at cycle T copies every live counter and status word into the shadow bank at the T+1 edge. The copy excludes cycle T's events; those land in the live counters only.
- **Clear:** `clr_req` at cycle T zeroes all live counters and `sat` bits at the T+1 edge. Cycle-T events are discarded. FSM state is not cleared.
- **Snapshot and clear in the same cycle:** the shadow captures the pre-clear values, giving an atomic read-and-clear with no events lost beyond cycle T.
- **Reads:**
  - Reads always return shadow values, never live ones.
  - A channel field ≥ `NUM_CH` returns 0 with `rd_valid` still asserted.
  - `rd_en` may be asserted every cycle.
  - A read issued in the same cycle as `snap_req` returns the old shadow value.
- **Error flag:** `err_irq` is registered, equal to the OR over all channels of (`err_sop != 0` | `err_nosop != 0`), using live counters.

## Timing
- Counter update latency is 1 cycle after the event.
- `err_irq` follows the live counters by 1 further cycle, i.e. it rises 2 cycles after the offending beat.
- Read latency is 1 cycle: `rd_en` at T gives `rd_data`/`rd_valid` at T+1. `rd_valid` is low whenever `rd_en` was low the cycle before. `rd_data` holds its last value when not reading.
- **Reset (`rst_n=0` at a rising edge):**
  - All live counters, shadows and `sat` bits go to 0.
  - All FSMs go to IDLE.
  - `rd_data=0`, `rd_valid=0`, `err_irq=0`.
  - A reset in the middle of a packet drops the packet context: the next non-SOP beat counts as `err_nosop`.
- The monitor never drives or alters the monitored streams. Inputs are sampled only.
- Each channel's byte adder is registered alone with no cross-channel arithmetic. The critical path is one `CNT_W` add plus the saturation mux.

## Test plan
- **3-beat packet:** ch0 accepts (sop), (mid), (eop, empty=10) with back-to-back ready. Then snap and read ch0.
  - Required: flits=3, pkts=1, sops=1, bytes=182, stalls=0, errors=0, `in_pkt=0`.
- **Stalls:** ch1 holds valid with ready low for 5 cycles, then accepts a 1-beat packet (sop, eop, empty=0).
  - Required: stalls=5, flits=1, bytes=64.
- **Framing errors:** ch2 sends (sop), (sop, eop), then (mid, eop) while idle.
  - Required: `err_sop=1`, `err_nosop=1`, pkts=2, `in_pkt=0`.
  - Required: `err_irq` rises 2 cycles after the first error beat and falls 1 cycle after `clr_req`.
- **Saturation:** with `CNT_W=16, SAT=1`, drive 65 540 accepted single-beat packets on ch3.
  - Required: flits=0xFFFF and `sat[0]=1`.
  - Required: with `SAT=0`, flits=4.
- **Atomic read-and-clear:** `snap_req` and `clr_req` together while ch0 accepts a beat in the same cycle.
  - Required: the shadow holds the pre-event count, live flits = 0, and the next beat makes live flits = 1.
- **Reset mid-packet and out-of-range read:** assert reset during an ch0 IN_PKT, then send (mid, eop).
  - Required: `err_nosop=1`.
  - Required: reading channel `NUM_CH` returns 0 with `rd_valid=1`.
